// File: rtl/demod_mc.sv
// -----------------------------------------------------------------------------
// demod_mc -- time-multiplexed multi-channel FM quadrature demodulator.
//
// Pops one interleaved I/Q pair at a time from the rl/img FIFOs. Channels are
// assigned in strict round-robin order. Each channel keeps its own previous
// sample. The block forms the conjugate product with that previous sample and
// estimates the phase step with an internal restoring divider. The gain-scaled
// phase difference is pushed to the demod FIFO, tagged with its channel.
//
// Optional build macro:
//   DEMOD_MC_SAT_EN  saturate the written value to the signed OUT_WIDTH range
//                    instead of keeping the low OUT_WIDTH bits.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-low reset
//   rl/img       FIFO head samples (signed, FRAC_BITS fixed point)
//   empty_rl/img FIFO empty flags
//   rd_en_rl/img FIFO pops; always pulsed together for one cycle
//   demod_out    demodulated sample, held between writes
//   out_ch       channel tag of demod_out
//   full_demod   output FIFO full
//   wr_en_demod  output FIFO push
//   busy         high in any state other than READ
// -----------------------------------------------------------------------------
module demod_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int NUM_CH     = 1,
    parameter int QUAD1      = 804,
    parameter int GAIN       = 758,
    parameter int OUT_WIDTH  = 32,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] rl,
    input  logic                         empty_rl,
    output logic                         rd_en_rl,
    input  logic signed [DATA_WIDTH-1:0] img,
    input  logic                         empty_img,
    output logic                         rd_en_img,
    output logic        [OUT_WIDTH-1:0]  demod_out,
    output logic        [CH_W-1:0]       out_ch,
    input  logic                         full_demod,
    output logic                         wr_en_demod,
    output logic                         busy
);

    localparam int MSB   = DATA_WIDTH - 1;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic signed [MSB:0] Q1 = DATA_WIDTH'(QUAD1);
    localparam logic signed [MSB:0] Q3 = DATA_WIDTH'(3 * QUAD1);
    localparam logic signed [MSB:0] G  = DATA_WIDTH'(GAIN);

`ifdef DEMOD_MC_SAT_EN
    localparam logic signed [MSB:0] OUT_MAX =
        DATA_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [MSB:0] OUT_MIN = ~OUT_MAX;
`endif

    typedef enum logic [2:0] {READ, MULT, SETUP, DIVIDE, ANGLE, WRITE} state_t;

    // Fixed-point multiply: full-width product, floor shift, keep low bits.
    function automatic logic signed [MSB:0] mulq(input logic signed [MSB:0] a,
                                                 input logic signed [MSB:0] b);
        logic signed [2*DATA_WIDTH-1:0] ax;
        logic signed [2*DATA_WIDTH-1:0] bx;
        logic signed [2*DATA_WIDTH-1:0] p;
        ax = {{DATA_WIDTH{a[MSB]}}, a};
        bx = {{DATA_WIDTH{b[MSB]}}, b};
        p  = (ax * bx) >>> FRAC_BITS;
        return p[MSB:0];
    endfunction

    state_t                 state, state_nxt;
    logic                   rd_go, wr_go;

    logic [CH_W-1:0]        cnt;          // channel of the next sample to read
    logic [CH_W-1:0]        ch;           // channel of the sample in flight
    logic signed [MSB:0]    cur_r, cur_i;
    logic signed [MSB:0]    prev_r [NUM_CH];
    logic signed [MSB:0]    prev_i [NUM_CH];
    logic signed [MSB:0]    r_q, i_q;     // conjugate product
    logic                   dvd_neg;      // quotient takes the dividend's sign
    logic [MSB:0]           dvs;          // divisor magnitude (always >= 1)
    logic [DATA_WIDTH:0]    rem;          // one spare bit for the trial subtract
    logic [MSB:0]           quo;          // dividend shifts out, quotient shifts in
    logic [CNT_W-1:0]       bit_cnt;
    logic signed [MSB:0]    ang;

    // Datapath combinational terms.
    logic signed [MSB:0]    prod_r, prod_i;
    logic signed [MSB:0]    abs_i, ia, num, den;
    logic [MSB:0]           num_mag;
    logic [DATA_WIDTH:0]    div_shift, div_diff;
    logic signed [MSB:0]    quot, ang_raw, ang_nxt, scaled, sat_val;
    logic [OUT_WIDTH-1:0]   out_nxt;

    assign busy = (state != READ);

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rd_go     = 1'b0;
        wr_go     = 1'b0;
        unique case (state)
            READ: begin
                if (!empty_rl && !empty_img) begin
                    rd_go     = 1'b1;
                    state_nxt = MULT;
                end
            end
            MULT:   state_nxt = SETUP;
            SETUP:  state_nxt = DIVIDE;
            DIVIDE: if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state_nxt = ANGLE;
            ANGLE:  state_nxt = WRITE;
            WRITE: begin
                if (!full_demod) begin
                    wr_go     = 1'b1;
                    state_nxt = READ;
                end
            end
            default: state_nxt = READ;
        endcase
    end

    always_comb begin
        prod_r = mulq(prev_r[ch], cur_r) + mulq(prev_i[ch], cur_i);
        prod_i = mulq(prev_r[ch], cur_i) - mulq(prev_i[ch], cur_r);

        abs_i  = i_q[MSB] ? -i_q : i_q;
        ia     = abs_i + DATA_WIDTH'(1);
        if (!r_q[MSB]) begin
            num = (r_q - ia) <<< FRAC_BITS;
            den = r_q + ia;
        end else begin
            num = (r_q + ia) <<< FRAC_BITS;
            den = ia - r_q;
        end
        num_mag = num[MSB] ? -num : num;

        // Trial subtract: a clear top bit means the divisor fits.
        div_shift = {rem[MSB:0], quo[MSB]};
        div_diff  = div_shift - {1'b0, dvs};

        quot    = dvd_neg ? -quo : quo;
        ang_raw = (r_q[MSB] ? Q3 : Q1) - mulq(Q1, quot);
        ang_nxt = i_q[MSB] ? -ang_raw : ang_raw;

        scaled  = mulq(G, ang);
`ifdef DEMOD_MC_SAT_EN
        if (scaled > OUT_MAX)      sat_val = OUT_MAX;
        else if (scaled < OUT_MIN) sat_val = OUT_MIN;
        else                       sat_val = scaled;
`else
        sat_val = scaled;
`endif
        out_nxt = sat_val[OUT_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= READ;
            cnt         <= '0;
            ch          <= '0;
            cur_r       <= '0;
            cur_i       <= '0;
            r_q         <= '0;
            i_q         <= '0;
            dvd_neg     <= 1'b0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            bit_cnt     <= '0;
            ang         <= '0;
            rd_en_rl    <= 1'b0;
            rd_en_img   <= 1'b0;
            wr_en_demod <= 1'b0;
            demod_out   <= '0;
            out_ch      <= '0;
            // NOTE: the history registers are cleared explicitly because the
            // first sample of each channel after reset must see a zero
            // previous sample.
            for (int k = 0; k < NUM_CH; k++) begin
                prev_r[k] <= '0;
                prev_i[k] <= '0;
            end
        end else begin
            state       <= state_nxt;
            rd_en_rl    <= rd_go;
            rd_en_img   <= rd_go;
            wr_en_demod <= wr_go;
            unique case (state)
                READ: begin
                    if (rd_go) begin
                        cur_r <= rl;
                        cur_i <= img;
                        ch    <= cnt;
                    end
                end
                MULT: begin
                    r_q        <= prod_r;
                    i_q        <= prod_i;
                    prev_r[ch] <= cur_r;
                    prev_i[ch] <= cur_i;
                end
                SETUP: begin
                    dvd_neg <= num[MSB];
                    quo     <= num_mag;
                    dvs     <= den;
                    rem     <= '0;
                    bit_cnt <= '0;
                end
                DIVIDE: begin
                    if (!div_diff[DATA_WIDTH]) begin
                        rem <= div_diff;
                        quo <= {quo[MSB-1:0], 1'b1};
                    end else begin
                        rem <= div_shift;
                        quo <= {quo[MSB-1:0], 1'b0};
                    end
                    bit_cnt <= bit_cnt + 1'b1;
                end
                ANGLE: ang <= ang_nxt;
                WRITE: begin
                    if (wr_go) begin
                        demod_out <= out_nxt;
                        out_ch    <= ch;
                        cnt       <= (cnt == CH_W'(NUM_CH - 1)) ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/demod_mc.md
Name: demod_mc

Overview:
Parametrised, time-multiplexed multi-channel FM quadrature demodulator; successor to the single-channel demod stage.
- Reads interleaved I/Q sample pairs from the rl/img FIFOs.
- Samples belong to channels 0..NUM_CH-1 in strict round-robin order.
- Keeps a per-channel previous sample and computes the conjugate product.
- Estimates phase with an internal sequential divider (no external divider instance).
- Writes the gain-scaled phase difference, tagged with its channel, to the demod FIFO.

Parameters:
- DATA_WIDTH, 32: sample, product and divider width; signed.
- FRAC_BITS, 10: fixed-point fractional bits for all quantities.
- NUM_CH, 1: channel count, 1..16; per-channel previous-sample registers.
- QUAD1, 804: pi/4 in FRAC_BITS fixed point. QUAD3 = 3*QUAD1, derived internally.
- GAIN, 758: output gain, FRAC_BITS fixed point.
- OUT_WIDTH, 32: demod_out width, <= DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- rl  in  DATA_WIDTH  real sample, FIFO head.
- empty_rl  in  1  real FIFO empty.
- rd_en_rl  out  1  real FIFO pop.
- img  in  DATA_WIDTH  imaginary sample, FIFO head.
- empty_img  in  1  imaginary FIFO empty.
- rd_en_img  out  1  imaginary FIFO pop.
- demod_out  out  OUT_WIDTH  demodulated sample.
- out_ch  out  max(1,$clog2(NUM_CH))  channel tag of demod_out.
- full_demod  in  1  output FIFO full.
- wr_en_demod  out  1  output FIFO push.
- busy  out  1  high in any state other than READ.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=READ; channel counter=0.
  - All prev_r/prev_i=0; divider cleared.
  - rd_en_*, wr_en_demod and busy=0; demod_out and out_ch=0.
  - Reset mid-operation abandons the sample in flight with no write, including reset during DIVIDE.
- mulq(a,b) = (a*b) arithmetic-shifted right by FRAC_BITS. The full 2*DATA_WIDTH product is formed, then the low DATA_WIDTH bits are kept.
- READ:
  - When empty_rl==0 && empty_img==0, pulse rd_en_rl and rd_en_img together for exactly 1 cycle.
  - Latch cur=(rl,img) and ch=counter. Go to MULT.
  - Never pops one FIFO without the other.
- MULT:
  - r = mulq(prev_r[ch],cur_r) + mulq(prev_i[ch],cur_i).
  - i = mulq(prev_r[ch],cur_i) - mulq(prev_i[ch],cur_r).
  - prev[ch] <= cur.
  - Go to SETUP.
- SETUP:
  - ia = |i| + 1.
  - If r>=0: dividend=(r-ia)<<FRAC_BITS, divisor=r+ia.
  - Else: dividend=(r+ia)<<FRAC_BITS, divisor=ia-r.
  - Divisor is always >=1, so there is no divide-by-zero path.
- DIVIDE:
  - Restoring division on magnitudes, exactly DATA_WIDTH cycles.
  - Quotient is truncated toward zero, with the sign of the dividend.
- ANGLE:
  - t = mulq(QUAD1,q).
  - a = QUAD1 - t if r>=0, else QUAD3 - t.
  - Negate a if i<0.
- WRITE:
  - Hold until full_demod==0, then pulse wr_en_demod for 1 cycle.
  - demod_out = mulq(GAIN,a) narrowed to OUT_WIDTH; out_ch=ch.
  - Counter wraps NUM_CH-1 -> 0. Return to READ.
- Latency (FIFOs non-empty, output not full):
  - rd_en to wr_en_demod = DATA_WIDTH+4 cycles.
  - One sample per DATA_WIDTH+5 cycles.
- full_demod asserted in any state before WRITE has no effect until WRITE.
- The first sample of each channel after reset uses prev=0 (r=i=0) and produces a defined, nonzero output.
- demod_out and out_ch are held between writes.

Optional Feature:
DEMOD_MC_SAT_EN
- Defined: the WRITE value saturates to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: low OUT_WIDTH bits are kept (two's-complement wrap).
- Has no effect when OUT_WIDTH==DATA_WIDTH.

Test Plan:
- NUM_CH=1, after reset push (1024,0) then (1024,0) -> outputs 1190 (first sample), then 1 (q=1022, a=2); exactly DATA_WIDTH+4 cycles from rd_en to each wr_en.
- Prev (1024,0), push (0,1024) -> 1190 (a=1608). Prev (1024,0), push (0,-1024) -> -1191 (a=-1608, floor shift).
- NUM_CH=2, interleave ch0:(1024,0),(1024,0) and ch1:(0,1024),(0,1024) -> out_ch 0,1,0,1; values 1190,1190,1,1. Channel histories are not mixed.
- Hold full_demod=1 for 20 cycles at WRITE -> wr_en_demod=0, no FIFO pops, demod_out stable. Release -> single write, then resume.
- Drop rst to 0 mid-DIVIDE, release, push (1024,0) -> no stale write; output 1190 (prev cleared).
- OUT_WIDTH=8, first sample -> 127 with DEMOD_MC_SAT_EN; -90 (wrapped 1190) without.
